ub_stream_buffer: RTL

Unified buffer, second generation: a parametrised single-clock RAM with a byte-masked host write port and a burst read engine. The engine streams a contiguous, wrap-around range of words to the vector multiplier array over a valid/ready handshake and absorbs backpressure without losing words. It sits between the host/DMA loader and the array input skew stage, replacing the plain one-address read/write buffer.

---
 rtl/ub_stream_buffer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ub_stream_buffer.sv
// ub_stream_buffer: unified buffer with a byte-masked host write port and a burst read engine.
// A burst streams `length` consecutive words (wrapping at the top of memory) from `base_addr`
// over a valid/ready handshake. A two-entry output FIFO behind the synchronous RAM read absorbs
// backpressure, and a credit check keeps reads in flight from overrunning it.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   wr_en/wr_addr/     host write; wr_mask bit i enables byte lane i
//   wr_data/wr_mask
//   start/base_addr/   burst request and parameters, sampled only while idle
//   length
//   busy               burst engine active
//   out_valid/         streamed word and handshake
//   out_ready/out_data
//   done               one-cycle pulse when a burst has fully drained
module ub_stream_buffer #(
  parameter int unsigned ADDRESSSIZE = 10,
  parameter int unsigned WORDSIZE    = 160,
  localparam int unsigned LANES      = WORDSIZE / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDRESSSIZE-1:0] wr_addr,
  input  logic [WORDSIZE-1:0]    wr_data,
  input  logic [LANES-1:0]       wr_mask,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE:0]   length,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDSIZE-1:0]    out_data,
  output logic                   done
);

  localparam int unsigned Depth = 2 ** ADDRESSSIZE;

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  logic [WORDSIZE-1:0]    mem [Depth];
  logic [WORDSIZE-1:0]    rd_data_q;

  state_e                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRESSSIZE:0]   remaining_q, remaining_d;
  logic                   inflight_q;

  logic [WORDSIZE-1:0]    fifo_q [2];
  logic                   fifo_rd_q, fifo_wr_q;
  logic [1:0]             fifo_cnt_q;

  logic                   pop, push, issue;
  logic [1:0]             occupancy;

  // Memory is never reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_mask[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Separate non-blocking read gives read-first behaviour on a same-edge write.
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  always_comb begin
    out_valid = (fifo_cnt_q != 2'd0);
    out_data  = fifo_q[fifo_rd_q];
    pop       = out_valid & out_ready;
    push      = inflight_q;
    busy      = (state_q != StIdle);
    // Words already buffered or on their way must leave room for the next read.
    occupancy = fifo_cnt_q + {1'b0, inflight_q};
    issue     = (state_q == StRun) && ((occupancy - {1'b0, pop}) < 2'd2);
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rd_ptr_d    = base_addr;
          remaining_d = length;
          state_d     = (length != '0) ? StRun : StFlush;
        end
      end
      StRun: begin
        if (issue) begin
          rd_ptr_d    = rd_ptr_q + ADDRESSSIZE'(1);
          remaining_d = remaining_q - (ADDRESSSIZE + 1)'(1);
          if (remaining_q == (ADDRESSSIZE + 1)'(1)) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if ((fifo_cnt_q == 2'd0) && !inflight_q) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      inflight_q  <= issue;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[fifo_wr_q] <= rd_data_q;
        fifo_wr_q         <= ~fifo_wr_q;
      end
      if (pop) begin
        fifo_rd_q <= ~fifo_rd_q;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule
